tape_input_loader: RTL and testbench

- Upstream stage of the Turing-machine core: turns raw chip pins (4-bit symbol switches, Next and Done buttons) into a clean tape-write stream plus a start pulse.
- Synchronizes and debounces the buttons, writes one symbol per Next press into tape cells 0..TAPE_LEN-1, then issues a single-cycle start to the core.
- Holds off all input while the core computes, and re-arms for a new tape after the core reports completion.

---
 rtl/tape_input_loader.sv | 208 ++++++++++++++++++++
 tb/tb_tape_input_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_input_loader.sv
// Tape input loader: synchronizes and debounces the front-panel buttons,
// streams one switch symbol into the tape per Next press, then launches the
// core with a single start pulse and waits for it to finish before re-arming.
module tape_input_loader #(
    parameter int DATA_W     = 4,
    parameter int TAPE_LEN   = 64,
    parameter int ADDR_W     = $clog2(TAPE_LEN),
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              next_btn,
    input  logic              done_btn,
    input  logic              compute_done,
    output logic              tape_we,
    output logic [ADDR_W-1:0] tape_addr,
    output logic [DATA_W-1:0] tape_wdata,
    output logic              start,
    output logic              loading,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [7:0]      DEB_MAX  = 8'(DEB_CYCLES);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(TAPE_LEN);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    // Two-flop synchronizers
    logic              next_meta_q, next_sync_q;
    logic              done_meta_q, done_sync_q;
    logic [DATA_W-1:0] data_meta_q, data_sync_q;

    // Debouncers: accepted level, stability counter, rise pulse
    logic       next_deb_q, next_deb_d;
    logic [7:0] next_cnt_q, next_cnt_d;
    logic       next_press_q, next_press_d;
    logic       done_deb_q, done_deb_d;
    logic [7:0] done_cnt_q, done_cnt_d;
    logic       done_press_q, done_press_d;

    // Control state and registered outputs
    state_t            state_q, state_d;
    logic              tape_we_q, tape_we_d;
    logic [ADDR_W-1:0] tape_addr_q, tape_addr_d;
    logic [DATA_W-1:0] tape_wdata_q, tape_wdata_d;
    logic              start_q, start_d;
    logic              loading_q, loading_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    // Bring the raw pins into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            next_meta_q <= 1'b0;
            next_sync_q <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            next_meta_q <= next_btn;
            next_sync_q <= next_meta_q;
            done_meta_q <= done_btn;
            done_sync_q <= done_meta_q;
            data_meta_q <= data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // Debounce both buttons; a press pulse fires only on an accepted 0->1 flip
    always_comb begin
        next_deb_d   = next_deb_q;
        next_cnt_d   = 8'd0;
        next_press_d = 1'b0;
        if (next_sync_q != next_deb_q) begin
            if ((next_cnt_q + 8'd1) == DEB_MAX) begin
                next_deb_d   = ~next_deb_q;
                next_press_d = ~next_deb_q;
            end else begin
                next_cnt_d = next_cnt_q + 8'd1;
            end
        end else begin
            next_cnt_d = 8'd0;
        end

        done_deb_d   = done_deb_q;
        done_cnt_d   = 8'd0;
        done_press_d = 1'b0;
        if (done_sync_q != done_deb_q) begin
            if ((done_cnt_q + 8'd1) == DEB_MAX) begin
                done_deb_d   = ~done_deb_q;
                done_press_d = ~done_deb_q;
            end else begin
                done_cnt_d = done_cnt_q + 8'd1;
            end
        end else begin
            done_cnt_d = 8'd0;
        end
    end

    // Debouncer state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            next_deb_q   <= 1'b0;
            next_cnt_q   <= 8'd0;
            next_press_q <= 1'b0;
            done_deb_q   <= 1'b0;
            done_cnt_q   <= 8'd0;
            done_press_q <= 1'b0;
        end else begin
            next_deb_q   <= next_deb_d;
            next_cnt_q   <= next_cnt_d;
            next_press_q <= next_press_d;
            done_deb_q   <= done_deb_d;
            done_cnt_q   <= done_cnt_d;
            done_press_q <= done_press_d;
        end
    end

    // Load/start/run sequencing; Done takes priority over a simultaneous Next
    always_comb begin
        state_d      = state_q;
        tape_we_d    = 1'b0;
        tape_addr_d  = tape_addr_q;
        tape_wdata_d = tape_wdata_q;
        start_d      = 1'b0;
        count_d      = count_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_LOAD: begin
                if (done_press_q) begin
                    if (count_q != '0) begin
                        state_d = ST_START;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (next_press_q) begin
                    if (count_q != CNT_FULL) begin
                        tape_we_d    = 1'b1;
                        tape_addr_d  = count_q[ADDR_W-1:0];
                        tape_wdata_d = data_sync_q;
                        count_d      = count_q + CNT_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (done_press_q && compute_done) begin
                    state_d    = ST_LOAD;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        loading_d = (state_d == ST_LOAD);
    end

    // Control state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            tape_we_q    <= 1'b0;
            tape_addr_q  <= '0;
            tape_wdata_q <= '0;
            start_q      <= 1'b0;
            loading_q    <= 1'b1;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tape_we_q    <= tape_we_d;
            tape_addr_q  <= tape_addr_d;
            tape_wdata_q <= tape_wdata_d;
            start_q      <= start_d;
            loading_q    <= loading_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tape_we    = tape_we_q;
    assign tape_addr  = tape_addr_q;
    assign tape_wdata = tape_wdata_q;
    assign start      = start_q;
    assign loading    = loading_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tape_input_loader.sv
// Directed bench for tape_input_loader (DATA_W=4, TAPE_LEN=64, DEB_CYCLES=4).
module tb_tape_input_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       next_btn;
    logic       done_btn;
    logic       compute_done;
    logic       tape_we;
    logic [5:0] tape_addr;
    logic [3:0] tape_wdata;
    logic       start;
    logic       loading;
    logic [6:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int start_cnt = 0;
    int both_hi = 0;
    int start_loading_hi = 0;
    int last_addr = -1;
    int last_data = -1;
    int wr_addr[$];
    int wr_data[$];
    int base_we;
    int base_start;

    tape_input_loader #(
        .DATA_W(4), .TAPE_LEN(64), .DEB_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .next_btn(next_btn), .done_btn(done_btn), .compute_done(compute_done),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
        .start(start), .loading(loading), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then observe outputs 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        if (tape_we === 1'b1) begin
            we_cnt++;
            last_addr = int'(tape_addr);
            last_data = int'(tape_wdata);
            wr_addr.push_back(int'(tape_addr));
            wr_data.push_back(int'(tape_wdata));
        end
        if (start === 1'b1) begin
            start_cnt++;
            if (loading !== 1'b0) start_loading_hi++;
        end
        if (tape_we === 1'b1 && start === 1'b1) both_hi++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_btn = 1'b0;
        done_btn = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic tap_next(input logic [3:0] d);
        data_in = d;
        next_btn = 1'b1;
        ticks(10);
        next_btn = 1'b0;
        ticks(10);
    endtask

    task automatic tap_done();
        done_btn = 1'b1;
        ticks(10);
        done_btn = 1'b0;
        ticks(10);
    endtask

    initial begin
        reset = 1'b1;
        data_in = 4'h0;
        next_btn = 1'b0;
        done_btn = 1'b0;
        compute_done = 1'b0;

        // Reset values
        do_reset();
        chk("rst_we", tape_we, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_loading", loading, 1'b1);
        chk("rst_count", count, 7'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_addr", tape_addr, 6'd0);
        chk("rst_wdata", tape_wdata, 4'h0);

        // Test 1: exact latency of first write
        data_in = 4'hA;
        next_btn = 1'b1;
        ticks(6);
        chk("t1_we_k6", tape_we, 1'b0);
        tick();
        chk("t1_we_k7", tape_we, 1'b1);
        chk("t1_addr", tape_addr, 6'd0);
        chk("t1_wdata", tape_wdata, 4'hA);
        chk("t1_count", count, 7'd1);
        tick();
        chk("t1_we_k8", tape_we, 1'b0);
        chk("t1_addr_hold", tape_addr, 6'd0);
        ticks(2);
        next_btn = 1'b0;
        ticks(10);
        chk("t1_total_we", we_cnt, 1);

        // Test 2: bouncing Next never reaches the debounce threshold
        do_reset();
        base_we = we_cnt;
        for (int i = 0; i < 20; i++) begin
            next_btn = ~next_btn;
            tick();
        end
        next_btn = 1'b0;
        ticks(12);
        chk("t2_no_we", we_cnt - base_we, 0);
        chk("t2_count", count, 7'd0);

        // Test 3: three symbols, Done, then Next ignored
        do_reset();
        base_start = start_cnt;
        tap_next(4'h1);
        tap_next(4'h2);
        tap_next(4'h3);
        chk("t3_nwr", wr_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_addr", wr_addr[i], i);
            chk("t3_data", wr_data[i], i + 1);
        end
        chk("t3_count", count, 7'd3);
        tap_done();
        chk("t3_start_once", start_cnt - base_start, 1);
        chk("t3_loading", loading, 1'b0);
        base_we = we_cnt;
        tap_next(4'h5);
        chk("t3_run_no_we", we_cnt - base_we, 0);
        chk("t3_run_count", count, 7'd3);

        // Test 4: fill the tape, overflow, run, re-arm
        do_reset();
        base_we = we_cnt;
        for (int i = 0; i < 64; i++) tap_next(4'(i));
        chk("t4_nwr", we_cnt - base_we, 64);
        chk("t4_addr10", wr_addr[10], 10);
        chk("t4_data10", wr_data[10], 10);
        chk("t4_last_addr", last_addr, 63);
        chk("t4_last_data", last_data, 15);
        chk("t4_count_full", count, 7'd64);
        chk("t4_ovf_before", overflow, 1'b0);
        tap_next(4'h7);
        chk("t4_ovf_no_we", we_cnt - base_we, 64);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_count_sat", count, 7'd64);
        base_start = start_cnt;
        tap_done();
        chk("t4_start", start_cnt - base_start, 1);
        compute_done = 1'b0;
        tap_done();
        chk("t4_done_not_ready", loading, 1'b0);
        compute_done = 1'b1;
        tap_done();
        compute_done = 1'b0;
        chk("t4_rearm_loading", loading, 1'b1);
        chk("t4_rearm_count", count, 7'd0);
        chk("t4_rearm_ovf", overflow, 1'b0);
        chk("t4_no_extra_start", start_cnt - base_start, 1);

        // Test 5: Done with empty tape ignored; Next+Done together
        base_start = start_cnt;
        tap_done();
        chk("t5_empty_done", start_cnt - base_start, 0);
        chk("t5_still_load", loading, 1'b1);
        tap_next(4'h9);
        tap_next(4'h4);
        chk("t5_count2", count, 7'd2);
        base_we = we_cnt;
        next_btn = 1'b1;
        done_btn = 1'b1;
        ticks(10);
        next_btn = 1'b0;
        done_btn = 1'b0;
        ticks(10);
        chk("t5_both_start", start_cnt - base_start, 1);
        chk("t5_both_no_we", we_cnt - base_we, 0);
        chk("t5_both_count", count, 7'd2);

        // Test 6a: reset while in RUN
        reset = 1'b1;
        tick();
        chk("t6_run_loading", loading, 1'b1);
        chk("t6_run_count", count, 7'd0);
        chk("t6_run_start", start, 1'b0);
        reset = 1'b0;
        tick();
        chk("t6_run_after_we", tape_we, 1'b0);
        chk("t6_run_after_start", start, 1'b0);

        // Test 6b: reset while a Next press pulse is pending
        ticks(3);
        base_we = we_cnt;
        base_start = start_cnt;
        data_in = 4'hC;
        next_btn = 1'b1;
        ticks(6);
        reset = 1'b1;
        next_btn = 1'b0;
        tick();
        chk("t6_pend_we", tape_we, 1'b0);
        chk("t6_pend_count", count, 7'd0);
        reset = 1'b0;
        tick();
        chk("t6_pend_after_we", tape_we, 1'b0);
        ticks(12);
        chk("t6_pend_no_write", we_cnt - base_we, 0);
        chk("t6_pend_no_start", start_cnt - base_start, 0);
        chk("t6_pend_loading", loading, 1'b1);

        // Global invariants
        chk("never_we_and_start", both_hi, 0);
        chk("start_implies_not_loading", start_loading_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
